// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the sequential calculator.
//   state_t : control FSM states (IDLE, OPER, MUL, DONE)
//   op_t    : latched operation encoding (OP_ADD, OP_SUB, OP_MUL)
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

endpackage

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative shift-add multiplier, one multiplier bit per cycle,
// LSB first, W iterations.
//   mclk  : clock, rising edge
//   reset : synchronous, active-low; aborts an iteration without a done pulse
//   start : one-cycle request; a and b are captured on this edge
//   a     : OW-bit multiplicand
//   b     : W-bit multiplier
//   busy  : high for the W cycles after start while bits are being consumed
//   done  : one-cycle pulse once p/ovf hold the finished product
//   p     : product modulo 2^OW
//   ovf   : set when any product bit at or above OW is nonzero
// Protocol: start is a fire-and-forget request (no ready); the caller must not
// raise start again until done has pulsed. done pulses exactly once per start
// unless reset intervenes.
module shift_add_mul #(
  parameter  int W  = 7,
  localparam int OW = 2 * W
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic          start,
  input  logic [OW-1:0] a,
  input  logic [W-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic [OW-1:0] p,
  output logic          ovf
);

  // Full product of an OW-bit by W-bit operand fits in OW+W bits, which keeps
  // the overflow bits visible until the final cycle.
  localparam int PW = OW + W;
  localparam int CW = $clog2(W + 1);

  logic [PW-1:0] a_sh;
  logic [PW-1:0] sum_q;
  logic [PW-1:0] sum_nxt;
  logic [W-1:0]  b_sh;
  logic [CW-1:0] cnt;

  assign sum_nxt = sum_q + (b_sh[0] ? a_sh : '0);

  always_ff @(posedge mclk) begin
    if (!reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum_q <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        a_sh  <= PW'(a);
        b_sh  <= b;
        sum_q <= '0;
        cnt   <= '0;
      end else if (busy) begin
        sum_q <= sum_nxt;
        a_sh  <= a_sh << 1;
        b_sh  <= b_sh >> 1;
        cnt   <= cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          p    <= sum_nxt[OW-1:0];
          ovf  <= |sum_nxt[PW-1:OW];
        end
      end
    end
  end

endmodule

// File: rtl/seq_calculator.sv
// seq_calculator: button-driven sequential calculator (add, sub, multiply)
// with result chaining.
//   mclk    : clock, rising edge
//   reset   : synchronous, active-low
//   bin     : W-bit unsigned operand switches
//   btn_add, btn_sub, btn_mul, btn_eq, btn_clr : level buttons, edge-detected
//   outbin  : OW-bit display value (operand passthrough or result)
//   busy    : high while the multiplier iterates
//   done    : one-cycle pulse when a result is written to outbin
//   ovf     : carry / borrow / multiply overflow of the last result
module seq_calculator
  import calc_pkg::*;
#(
  parameter  int W  = 7,
  localparam int OW = 2 * W
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic [W-1:0]  bin,
  input  logic          btn_add,
  input  logic          btn_sub,
  input  logic          btn_mul,
  input  logic          btn_eq,
  input  logic          btn_clr,
  output logic [OW-1:0] outbin,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  state_t state;
  state_t next_state;
  op_t    op_q;
  op_t    sel_op;

  logic [OW-1:0] acc;
  logic [OW-1:0] zbin;
  logic [OW:0]   sum_ext;
  logic [OW-1:0] diff;
  logic          borrow;

  // Button order: {clr, eq, mul, sub, add}
  logic [4:0] btn_now;
  logic [4:0] btn_prev;
  logic [4:0] press;
  logic       p_add, p_sub, p_mul, p_eq, p_clr;

  logic          any_op;
  logic          do_clr;
  logic          load_op;
  logic          exec;
  logic          mul_start;
  logic          mul_finish;
  logic          mul_busy;
  logic          mul_done;
  logic [OW-1:0] mul_p;
  logic          mul_ovf;

  // ---------------- button edge detection ----------------
  assign btn_now = {btn_clr, btn_eq, btn_mul, btn_sub, btn_add};

  // Prev levels reset to 1 so a button held through reset never counts as a
  // press; they keep tracking in every state, including MUL.
  always_ff @(posedge mclk) begin
    if (!reset) btn_prev <= '1;
    else        btn_prev <= btn_now;
  end

  assign press = btn_now & ~btn_prev;
  assign p_add = press[0];
  assign p_sub = press[1];
  assign p_mul = press[2];
  assign p_eq  = press[3];
  assign p_clr = press[4];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge mclk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (p_clr)       next_state = IDLE;
        else if (any_op) next_state = OPER;
      end
      OPER: begin
        if (p_clr)     next_state = IDLE;
        else if (p_eq) next_state = (op_q == OP_MUL) ? MUL : DONE;
      end
      MUL: begin
        if (mul_done) next_state = DONE;
      end
      DONE: begin
        if (p_clr)       next_state = IDLE;
        else if (any_op) next_state = OPER;
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------- FSM: decoded actions / outputs ----------------
  always_comb begin
    any_op     = p_add | p_sub | p_mul;
    // Simultaneous op presses: mul beats add beats sub.
    sel_op     = p_mul ? OP_MUL : (p_add ? OP_ADD : OP_SUB);
    // Clear is ignored only while the multiplier owns the datapath.
    do_clr     = p_clr && (state != MUL);
    load_op    = !do_clr && any_op && ((state == IDLE) || (state == DONE));
    exec       = !do_clr && p_eq && (state == OPER);
    mul_start  = exec && (op_q == OP_MUL);
    mul_finish = (state == MUL) && mul_done;
    busy       = mul_busy;
  end

  // ---------------- add/sub datapath ----------------
  assign zbin    = OW'(bin);
  assign sum_ext = {1'b0, acc} + {1'b0, zbin};
  assign diff    = acc - zbin;
  assign borrow  = zbin > acc;

  always_ff @(posedge mclk) begin
    if (!reset) begin
      acc    <= '0;
      outbin <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      op_q   <= OP_ADD;
    end else begin
      done <= 1'b0;
      if ((state == IDLE) || (state == OPER)) outbin <= zbin;

      if (do_clr) begin
        acc    <= '0;
        outbin <= '0;
        ovf    <= 1'b0;
      end else begin
        if (load_op) begin
          op_q <= sel_op;
          // From DONE the previous result stays as the first operand.
          if (state == IDLE) acc <= zbin;
        end
        if (exec && (op_q == OP_ADD)) begin
          acc    <= sum_ext[OW-1:0];
          outbin <= sum_ext[OW-1:0];
          ovf    <= sum_ext[OW];
          done   <= 1'b1;
        end
        if (exec && (op_q == OP_SUB)) begin
          acc    <= diff;
          outbin <= diff;
          ovf    <= borrow;
          done   <= 1'b1;
        end
        if (mul_finish) begin
          acc    <= mul_p;
          outbin <= mul_p;
          ovf    <= mul_ovf;
          done   <= 1'b1;
        end
      end
    end
  end

  // B is captured inside the multiplier on the start edge, so later bin
  // changes cannot disturb the product.
  shift_add_mul #(.W(W)) u_mul (
    .mclk  (mclk),
    .reset (reset),
    .start (mul_start),
    .a     (acc),
    .b     (bin),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p),
    .ovf   (mul_ovf)
  );

endmodule

// File: tb/tb_seq_calculator.sv
module tb_seq_calculator;
  import calc_pkg::*;

  localparam int W  = 7;
  localparam int OW = 2 * W;

  // ---------------- clock / reset ----------------
  logic mclk = 1'b0;
  logic reset;
  always #5 mclk = ~mclk;

  logic [W-1:0]  bin;
  logic          btn_add, btn_sub, btn_mul, btn_eq, btn_clr;
  logic [OW-1:0] outbin;
  logic          busy, done, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  seq_calculator #(.W(W)) dut (
    .mclk    (mclk),
    .reset   (reset),
    .bin     (bin),
    .btn_add (btn_add),
    .btn_sub (btn_sub),
    .btn_mul (btn_mul),
    .btn_eq  (btn_eq),
    .btn_clr (btn_clr),
    .outbin  (outbin),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear();
    btn_clr = 1'b1;
    step();
    btn_clr = 1'b0;
    step();
  endtask

  // Waits (bounded) for the done pulse after the eq edge; multiply latency
  // from the eq edge is W+1 edges.
  task automatic wait_result(input string tag, input int exp_val, input int exp_ovf);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, W + 1);
    check({tag, "_outbin"}, 32'(outbin), exp_val);
    check({tag, "_ovf"}, 32'(ovf), exp_ovf);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int dn;
    reset = 1'b0; bin = '0;
    btn_add = 1'b1; btn_sub = 1'b0; btn_mul = 1'b0; btn_eq = 1'b0; btn_clr = 1'b0;
    step(); step();
    check("rst_outbin", 32'(outbin), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));

    // add held through reset must not register as a press
    reset = 1'b1;
    step();
    check("held_thru_reset", 32'(dut.state), 32'(IDLE));
    btn_add = 1'b0;
    bin = 7'd25;
    step();
    check("idle_passthru", 32'(outbin), 25);

    // 25 + 17
    btn_add = 1'b1; step(); btn_add = 1'b0;
    bin = 7'd17; step();
    check("oper_state", 32'(dut.state), 32'(OPER));
    check("oper_passthru", 32'(outbin), 17);
    btn_eq = 1'b1; step(); btn_eq = 1'b0;
    check("add_outbin", 32'(outbin), 42);
    check("add_done", 32'(done), 1);
    check("add_ovf", 32'(ovf), 0);
    step();
    check("add_done_pulse", 32'(done), 0);
    check("add_hold", 32'(outbin), 42);

    btn_clr = 1'b1; step(); btn_clr = 1'b0;
    check("clr_outbin", 32'(outbin), 0);
    check("clr_state", 32'(dut.state), 32'(IDLE));
    step();

    // 5 - 9 borrows
    bin = 7'd5; btn_sub = 1'b1; step(); btn_sub = 1'b0;
    bin = 7'd9; step();
    btn_eq = 1'b1; step(); btn_eq = 1'b0;
    check("sub_outbin", 32'(outbin), 16380);
    check("sub_ovf", 32'(ovf), 1);
    check("sub_done", 32'(done), 1);
    clear();
    check("clr_ovf", 32'(ovf), 0);

    // eq in IDLE is ignored
    btn_eq = 1'b1; step(); btn_eq = 1'b0;
    check("eq_idle_state", 32'(dut.state), 32'(IDLE));
    check("eq_idle_done", 32'(done), 0);

    // add held 10 cycles, spanning the eq press: acts exactly once
    bin = 7'd3; btn_add = 1'b1; step();
    bin = 7'd4; step();
    btn_eq = 1'b1; step(); btn_eq = 1'b0;
    check("hold_result", 32'(outbin), 7);
    repeat (7) step();
    check("hold_state", 32'(dut.state), 32'(DONE));
    check("hold_outbin", 32'(outbin), 7);
    btn_add = 1'b0; step();
    clear();

    // 127 * 127, clr during MUL ignored, bin change during MUL ignored
    bin = 7'd127; btn_mul = 1'b1; step(); btn_mul = 1'b0;
    step();
    btn_eq = 1'b1; step(); btn_eq = 1'b0;
    bin = '0;
    check("mul_busy_start", 32'(busy), 1);
    for (int i = 1; i <= 7; i++) begin
      if (i == 2) btn_clr = 1'b1;
      if (i == 3) btn_clr = 1'b0;
      step();
      check("mul_busy", 32'(busy), (i < 7) ? 1 : 0);
      check("mul_no_early_done", 32'(done), 0);
    end
    step();
    check("mul_outbin", 32'(outbin), 16129);
    check("mul_done", 32'(done), 1);
    check("mul_ovf", 32'(ovf), 0);
    check("mul_state", 32'(dut.state), 32'(DONE));
    clear();

    // add + mul together: mul wins (6 * 7)
    bin = 7'd6; btn_add = 1'b1; btn_mul = 1'b1; step();
    btn_add = 1'b0; btn_mul = 1'b0;
    bin = 7'd7; btn_eq = 1'b1; step(); btn_eq = 1'b0;
    wait_result("prio_mul", 42, 0);
    clear();

    // add + sub together: add wins (10 + 3)
    bin = 7'd10; btn_add = 1'b1; btn_sub = 1'b1; step();
    btn_add = 1'b0; btn_sub = 1'b0;
    bin = 7'd3; btn_eq = 1'b1; step(); btn_eq = 1'b0;
    check("prio_add", 32'(outbin), 13);
    clear();

    // chain: 100 * 100 = 10000, then * 2 = 20000 mod 16384 = 3616
    bin = 7'd100; btn_mul = 1'b1; step(); btn_mul = 1'b0;
    btn_eq = 1'b1; step(); btn_eq = 1'b0;
    wait_result("chain1", 10000, 0);
    btn_mul = 1'b1; step(); btn_mul = 1'b0;
    check("chain_state", 32'(dut.state), 32'(OPER));
    bin = 7'd2; btn_eq = 1'b1; step(); btn_eq = 1'b0;
    wait_result("chain2", 3616, 1);

    // reset at MUL cycle 3 aborts with no done pulse
    btn_mul = 1'b1; step(); btn_mul = 1'b0;
    bin = 7'd3; btn_eq = 1'b1; step(); btn_eq = 1'b0;
    step(); step(); step();
    check("abort_in_mul", 32'(dut.state), 32'(MUL));
    reset = 1'b0; bin = '0; step();
    check("abort_outbin", 32'(outbin), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_ovf", 32'(ovf), 0);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    reset = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1) dn++;
    end
    check("abort_no_done", dn, 0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_calculator.md
SEQ_CALCULATOR -- requirements
Module: seq_calculator

Interface
REQ-001 SHALL have parameter W, default 7: operand width in bits, legal range 2..16.
REQ-002 SHALL have derived constant OW = 2*W: accumulator and result width.
REQ-003 SHALL have port mclk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port bin, input, W bits: operand switches, unsigned.
REQ-006 SHALL have ports btn_add, btn_sub, btn_mul, btn_eq, btn_clr, input, 1 bit each: level buttons, acted on at rising edge only.
REQ-007 SHALL have port outbin, output, OW bits: display value.
REQ-008 SHALL have port busy, output, 1 bit: high while a multiply iterates.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a result is written to outbin.
REQ-010 SHALL have port ovf, output, 1 bit: carry, borrow or multiply overflow of the last result.

Function
REQ-011 SHALL register each button's previous level; press = btn & ~btn_prev, evaluated in the same cycle the input rises; a held button acts once.
REQ-012 SHALL implement states IDLE, OPER, MUL and DONE.
REQ-013 IDLE: outbin = zero-extended bin each cycle; a press of add, sub or mul loads acc = bin, latches op and moves to OPER.
REQ-014 OPER: outbin = zero-extended bin each cycle; a btn_eq press executes the latched op with B = bin.
REQ-015 Add SHALL set acc = acc + B modulo 2^OW, with ovf = carry out, and go to DONE; outbin and done update on the edge that samples the btn_eq press.
REQ-016 Sub SHALL set acc = acc - B modulo 2^OW, with ovf = borrow (B > acc), and go to DONE with the same one-edge latency.
REQ-017 Mul SHALL enter MUL with busy = 1 and iterate shift-add over B bits LSB first, one bit per cycle, for exactly W cycles.
REQ-018 On the W-th MUL cycle, acc = product modulo 2^OW, ovf = any product bit at or above OW, busy = 0, done = 1, next state DONE.
REQ-019 Mul total latency SHALL be W+1 edges from the edge that samples the btn_eq press to the edge that updates outbin.
REQ-020 DONE: outbin holds acc; a press of add, sub or mul keeps acc as the first operand (chaining), latches the op and moves to OPER.
REQ-021 btn_clr press in any state except MUL SHALL set acc = 0, outbin = 0 and ovf = 0, and go to IDLE.
REQ-022 In MUL, all button presses including btn_clr SHALL be ignored; button prev registers still update.
REQ-023 Simultaneous op presses SHALL resolve with priority mul > add > sub; btn_clr beats all others; btn_eq in IDLE or DONE is ignored.
REQ-024 In OPER, op presses SHALL be ignored; the first latched op stands.
REQ-025 bin changes during MUL SHALL NOT affect the product; B is captured on the btn_eq press edge.

Reset
REQ-026 With reset = 0 at an mclk edge: state = IDLE; acc, outbin, busy, done and ovf = 0; button prev registers = 1.
REQ-027 Setting button prev registers to 1 at reset SHALL suppress presses from buttons held through reset.
REQ-028 Reset during MUL SHALL abort the iteration with no done pulse.

Structure
REQ-029 Package calc_pkg SHALL hold the state enum (IDLE, OPER, MUL, DONE) and the op encoding (OP_ADD, OP_SUB, OP_MUL).
REQ-030 The iterative multiplier SHALL be sub-module shift_add_mul, parameter W, with ports start, a[OW], b[W], busy, done, p[OW], ovf.
REQ-031 The top level SHALL contain the button edge detection, the FSM and the add/sub datapath.

Verification (W = 7)
REQ-032 bin = 25, press add; bin = 17, press eq -> next edge outbin = 42, done pulse, ovf = 0.
REQ-033 bin = 5, press sub; bin = 9, press eq -> outbin = 16380 (0x3FFC), ovf = 1.
REQ-034 bin = 127, press mul; bin = 127, press eq -> busy for 7 cycles, outbin = 16129 at eq edge + 8, ovf = 0.
REQ-035 Chain: 100 x 100 = 10000; press mul; bin = 2, press eq -> outbin = 20000 mod 16384 = 3616, ovf = 1.
REQ-036 Hold btn_add for 10 cycles -> single capture; press clr during MUL -> ignored, product completes.
REQ-037 Drive reset = 0 at MUL cycle 3 -> next edge all outputs 0, state IDLE, no done pulse.
